// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-128 key-schedule sequencer: one round key per clock into a local
// store of RK0..RK10, SubWord borrowed from a shared S-box through sub_in/sub_out.
module aes_key_sched_ctrl #(
    parameter int NR    = 10,
    parameter int KEY_W = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_valid,
    input  logic [KEY_W-1:0] key_in,
    output logic             key_ready,
    output logic             busy,
    output logic             keys_valid,
    output logic             done,
    input  logic [3:0]       rk_idx,
    output logic [KEY_W-1:0] rk_out,
    output logic             rk_idx_err,
    output logic [31:0]      sub_in,
    input  logic [31:0]      sub_out
);

    localparam logic [3:0] LAST = 4'(NR);

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        READY
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       round;
    logic [7:0]       rcon;
    logic [KEY_W-1:0] rk_mem [0:NR];

    logic             accept;
    logic             expand_we;
    logic             last_round;
    logic [KEY_W-1:0] prev_rk;
    logic [KEY_W-1:0] next_rk;
    logic [31:0]      t;
    logic [31:0]      n0;
    logic [31:0]      n1;
    logic [31:0]      n2;
    logic [31:0]      n3;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt  = state;
        key_ready  = 1'b0;
        busy       = 1'b0;
        accept     = 1'b0;
        expand_we  = 1'b0;
        sub_in     = 32'h0;
        prev_rk    = '0;
        last_round = (round == LAST);
        case (state)
            IDLE, READY: begin
                // rst has priority over a simultaneous key_valid.
                key_ready = !rst;
                accept    = key_valid && !rst;
                if (accept) begin
                    state_nxt = EXPAND;
                end
            end
            EXPAND: begin
                busy      = !rst;
                expand_we = !rst;
                prev_rk   = rk_mem[round - 4'd1];
                sub_in    = {prev_rk[23:0], prev_rk[31:24]};
                if (last_round) begin
                    state_nxt = READY;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One full AES-128 round-key step; SubWord(RotWord(w3)) arrives on sub_out.
    always_comb begin
        t       = sub_out ^ {rcon, 24'h0};
        n0      = prev_rk[127:96] ^ t;
        n1      = prev_rk[95:64] ^ n0;
        n2      = prev_rk[63:32] ^ n1;
        n3      = prev_rk[31:0] ^ n2;
        next_rk = {n0, n1, n2, n3};
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            round      <= 4'd0;
            rcon       <= 8'h01;
            keys_valid <= 1'b0;
            done       <= 1'b0;
            rk_out     <= '0;
            rk_idx_err <= 1'b0;
        end else begin
            done       <= 1'b0;
            rk_out     <= (rk_idx <= LAST) ? rk_mem[rk_idx] : '0;
            rk_idx_err <= (rk_idx > LAST);
            if (accept) begin
                round      <= 4'd1;
                rcon       <= 8'h01;
                keys_valid <= 1'b0;
            end else if (expand_we) begin
                round <= round + 4'd1;
                rcon  <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
                if (last_round) begin
                    keys_valid <= 1'b1;
                    done       <= 1'b1;
                end
            end
        end
    end

    // NOTE: the key store has no reset; keys_valid alone says whether its contents are usable.
    always_ff @(posedge clk) begin
        if (accept) begin
            rk_mem[0] <= key_in;
        end else if (expand_we) begin
            rk_mem[round] <= next_rk;
        end
    end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Self-checking bench for aes_key_sched_ctrl: S-box and key expansion are modelled
// from GF(2^8) arithmetic and the FIPS-197 word recurrence, with random keys.
module tb_aes_key_sched_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_valid;
    logic [127:0] key_in;
    logic         key_ready;
    logic         busy;
    logic         keys_valid;
    logic         done;
    logic [3:0]   rk_idx;
    logic [127:0] rk_out;
    logic         rk_idx_err;
    logic [31:0]  sub_in;
    logic [31:0]  sub_out;

    logic [7:0]   sbox [0:255];
    logic [7:0]   rcon_tab [0:9];
    logic [127:0] exp_rk [0:10];

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    aes_key_sched_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_in     (key_in),
        .key_ready  (key_ready),
        .busy       (busy),
        .keys_valid (keys_valid),
        .done       (done),
        .rk_idx     (rk_idx),
        .rk_out     (rk_out),
        .rk_idx_err (rk_idx_err),
        .sub_in     (sub_in),
        .sub_out    (sub_out)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
        logic [15:0] d;
        d = {b, b};
        return d[15-k -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    assign sub_out = sub_word(sub_in);

    // S-box = affine transform of the multiplicative inverse (b^254).
    task automatic build_sbox();
        logic [7:0] b;
        logic [7:0] inv;
        for (int v = 0; v < 256; v++) begin
            b   = 8'(v);
            inv = 8'h00;
            if (b != 8'h00) begin
                inv = 8'h01;
                for (int k = 0; k < 254; k++) inv = gmul(inv, b);
            end
            sbox[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        rcon_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    endtask

    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) t = sub_word({t[23:0], t[31:24]}) ^ {rcon_tab[i/4-1], 24'h0};
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Called #1 after a posedge. Accepts key, then watches 14 edges after the accept edge.
    task automatic run_expand(input logic [127:0] key, input logic hold_junk, input string tag);
        int kv_at;
        int busy_n;
        int done_n;
        int ready_bad;
        model_expand(key);
        key_in    = key;
        key_valid = 1'b1;
        check({tag, " ready_before"}, 128'(key_ready), 128'(1));
        @(posedge clk); #1;
        check({tag, " keys_valid_drop"}, 128'(keys_valid), 128'(0));
        check({tag, " ready_in_expand"}, 128'(key_ready), 128'(0));
        if (hold_junk) key_in = ~key;
        else key_valid = 1'b0;
        kv_at     = 0;
        busy_n    = int'(busy);
        done_n    = 0;
        ready_bad = 0;
        for (int n = 1; n <= 14; n++) begin
            @(posedge clk); #1;
            busy_n += int'(busy);
            done_n += int'(done);
            if (keys_valid && kv_at == 0) kv_at = n;
            if (hold_junk && n <= 9) ready_bad += int'(key_ready);
            if (n == 9) key_valid = 1'b0;
        end
        check({tag, " kv_latency"}, 128'(kv_at), 128'(10));
        check({tag, " busy_cycles"}, 128'(busy_n), 128'(10));
        check({tag, " done_pulses"}, 128'(done_n), 128'(1));
        check({tag, " sub_in_idle"}, 128'(sub_in), 128'(0));
        if (hold_junk) check({tag, " ready_seen"}, 128'(ready_bad), 128'(0));
    endtask

    task automatic read_rk(input int idx, input logic [127:0] exp, input string tag);
        rk_idx = 4'(idx);
        @(posedge clk); #1;
        check(tag, rk_out, exp);
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 16; i++) begin
            rk_idx = 4'(i);
            @(posedge clk); #1;
            check($sformatf("%s rk[%0d]", tag, i), rk_out, (i <= 10) ? exp_rk[i] : 128'h0);
            check($sformatf("%s err[%0d]", tag, i), 128'(rk_idx_err), 128'(i > 10));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        build_sbox();
        rst       = 1'b1;
        key_valid = 1'b1;
        key_in    = 128'h1;
        rk_idx    = 4'd12;
        @(posedge clk); #1;
        check("rst key_ready", 128'(key_ready), 128'(0));
        check("rst busy", 128'(busy), 128'(0));
        check("rst keys_valid", 128'(keys_valid), 128'(0));
        check("rst done", 128'(done), 128'(0));
        check("rst rk_out", rk_out, 128'h0);
        check("rst rk_idx_err", 128'(rk_idx_err), 128'(0));
        @(posedge clk); #1;
        check("rst wins over key_valid busy", 128'(busy), 128'(0));
        key_valid = 1'b0;
        rst       = 1'b0;
        #1;
        check("idle key_ready", 128'(key_ready), 128'(1));
        @(posedge clk); #1;

        // FIPS-197 key
        run_expand(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0, "fips");
        read_rk(1, 128'ha0fafe1788542cb123a339392a6c7605, "fips RK1 const");
        read_rk(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "fips RK10 const");
        read_rk(10, exp_rk[10], "fips RK10 model");

        // Reload from READY with the zero key
        run_expand(128'h0, 1'b0, "zero");
        read_rk(10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e, "zero RK10 const");
        read_rk(0, 128'h0, "zero RK0");

        // key_valid held with a different key during EXPAND
        run_expand(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1, "junk");
        read_rk(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "junk RK10 const");
        sweep("sweep");

        // Reset during the 5th EXPAND cycle
        key_in    = 128'h000102030405060708090a0b0c0d0e0f;
        key_valid = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("mid busy before rst", 128'(busy), 128'(1));
        rst = 1'b1;
        #1;
        check("mid rst key_ready", 128'(key_ready), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("mid rst busy", 128'(busy), 128'(0));
        check("mid rst keys_valid", 128'(keys_valid), 128'(0));
        check("mid rst idle ready", 128'(key_ready), 128'(1));
        @(posedge clk); #1;
        check("mid rst stays idle", 128'(busy), 128'(0));
        run_expand(128'h000102030405060708090a0b0c0d0e0f, 1'b0, "reload");
        sweep("reload");

        // Random keys
        for (int k = 0; k < 4; k++) begin
            run_expand({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)),
                       $sformatf("rand%0d", k));
            sweep($sformatf("rand%0d", k));
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
